// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer controller.
package fb_pkg;

  localparam int unsigned FB_WIDTH   = 320;
  localparam int unsigned FB_HEIGHT  = 240;
  localparam int unsigned FB_PIX_W   = 8;
  localparam int unsigned FB_COORD_W = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_addr_map.sv
// Maps a screen coordinate to a flat buffer address and flags out-of-range points.
module fb_addr_map #(
  parameter int unsigned WIDTH       = 320,
  parameter int unsigned HEIGHT      = 240,
  parameter int unsigned COORD_W     = 11,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr_c,
  output logic               in_range_c
);

  logic [COORD_W-1:0] bx;
  logic [COORD_W-1:0] by;
  logic [31:0]        lin;

  always_comb begin
    bx         = x >> SCALE_SHIFT;
    by         = y >> SCALE_SHIFT;
    in_range_c = (32'(bx) < WIDTH) && (32'(by) < HEIGHT);
    lin        = 32'(by) * WIDTH + 32'(bx);
    addr_c     = ADDR_W'(lin);
  end

endmodule

// File: rtl/framebuffer_ctrl.sv
// Framebuffer with one write and one registered read port, plus a
// one-pixel-per-cycle clear engine that also runs after every reset.
module framebuffer_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned     WIDTH       = FB_WIDTH,
  parameter int unsigned     HEIGHT      = FB_HEIGHT,
  parameter int unsigned     PIX_W       = FB_PIX_W,
  parameter int unsigned     COORD_W     = FB_COORD_W,
  parameter int unsigned     SCALE_SHIFT = 1,
  parameter logic [PIX_W-1:0] RESET_COLOR = '1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear_req,
  input  logic [PIX_W-1:0]   clear_color,
  input  logic               write_enable,
  input  logic [PIX_W-1:0]   data_in,
  input  logic [COORD_W-1:0] data_in_x,
  input  logic [COORD_W-1:0] data_in_y,
  input  logic               read_enable,
  input  logic [COORD_W-1:0] data_out_x,
  input  logic [COORD_W-1:0] data_out_y,
  output logic [PIX_W-1:0]   data_out,
  output logic               data_out_valid,
  output logic               busy,
  output logic               write_drop
);

  localparam int unsigned DEPTH  = WIDTH * HEIGHT;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LAST   = DEPTH - 1;

  fb_state_e          state_q;
  fb_state_e          state_d;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [PIX_W-1:0]   clr_color;
  logic               clr_last_c;

  logic [ADDR_W-1:0]  wr_addr_c;
  logic               wr_in_range_c;
  logic [ADDR_W-1:0]  rd_addr_c;
  logic               rd_in_range_c;

  logic               mem_we_c;
  logic [ADDR_W-1:0]  mem_waddr_c;
  logic [PIX_W-1:0]   mem_wdata_c;
  logic               wr_drop_c;

  logic [PIX_W-1:0]   mem [DEPTH];
  logic [PIX_W-1:0]   ram_q;
  logic               from_ram;
  logic [PIX_W-1:0]   fill_q;

  fb_addr_map #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .COORD_W(COORD_W),
    .SCALE_SHIFT(SCALE_SHIFT), .ADDR_W(ADDR_W)
  ) u_wr_map (
    .x(data_in_x), .y(data_in_y), .addr_c(wr_addr_c), .in_range_c(wr_in_range_c)
  );

  fb_addr_map #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .COORD_W(COORD_W),
    .SCALE_SHIFT(SCALE_SHIFT), .ADDR_W(ADDR_W)
  ) u_rd_map (
    .x(data_out_x), .y(data_out_y), .addr_c(rd_addr_c), .in_range_c(rd_in_range_c)
  );

  assign clr_last_c = (clr_cnt == ADDR_W'(LAST));

  // Reset lands in CLEAR so the buffer is always filled before first use.
  always_ff @(posedge clock) begin
    if (reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_req)  state_d = CLEAR;
      CLEAR:   if (clr_last_c) state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  // The clear engine owns the RAM write port; user writes are refused meanwhile.
  always_comb begin
    busy        = (state_q == CLEAR);
    mem_we_c    = write_enable && wr_in_range_c;
    mem_waddr_c = wr_addr_c;
    mem_wdata_c = data_in;
    wr_drop_c   = write_enable && !wr_in_range_c;
    if (state_q == CLEAR) begin
      mem_we_c    = 1'b1;
      mem_waddr_c = clr_cnt;
      mem_wdata_c = clr_color;
      wr_drop_c   = write_enable;
    end
  end

  // Colour is latched only on entry to a clear; requests mid-clear are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      clr_cnt   <= '0;
      clr_color <= RESET_COLOR;
    end else if (state_q == IDLE) begin
      if (clear_req) begin
        clr_cnt   <= '0;
        clr_color <= clear_color;
      end
    end else begin
      clr_cnt <= clr_last_c ? '0 : clr_cnt + ADDR_W'(1);
    end
  end

  // Simple dual-port RAM; the read returns pre-write contents on address collision.
  always_ff @(posedge clock) begin
    if (mem_we_c)    mem[mem_waddr_c] <= mem_wdata_c;
    if (read_enable) ram_q <= mem[rd_addr_c];
  end

  // Read-result source: RAM, or a fill value (clear colour / zero for out-of-range).
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out_valid <= 1'b0;
      from_ram       <= 1'b0;
      fill_q         <= '0;
      write_drop     <= 1'b0;
    end else begin
      data_out_valid <= read_enable;
      write_drop     <= wr_drop_c;
      if (read_enable) begin
        if (state_q == CLEAR) begin
          from_ram <= 1'b0;
          fill_q   <= clr_color;
        end else if (!rd_in_range_c) begin
          from_ram <= 1'b0;
          fill_q   <= '0;
        end else begin
          from_ram <= 1'b1;
        end
      end
    end
  end

  assign data_out = from_ram ? ram_q : fill_q;

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// Scoreboard bench for framebuffer_ctrl on an 8x4 buffer with 2:1 screen scaling.
module tb_framebuffer_ctrl;

  localparam int N  = 32;
  localparam int BW = 8;
  localparam int BH = 4;
  localparam int SC = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear_req;
  logic [7:0]  clear_color;
  logic        write_enable;
  logic [7:0]  data_in;
  logic [10:0] data_in_x, data_in_y;
  logic        read_enable;
  logic [10:0] data_out_x, data_out_y;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        busy;
  logic        write_drop;

  framebuffer_ctrl #(
    .WIDTH(8), .HEIGHT(4), .PIX_W(8), .COORD_W(11),
    .SCALE_SHIFT(1), .RESET_COLOR(8'hFF)
  ) dut (
    .clock(clock), .reset(reset),
    .clear_req(clear_req), .clear_color(clear_color),
    .write_enable(write_enable), .data_in(data_in),
    .data_in_x(data_in_x), .data_in_y(data_in_y),
    .read_enable(read_enable), .data_out_x(data_out_x), .data_out_y(data_out_y),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .busy(busy), .write_drop(write_drop)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit busy;
    bit drop;
    bit valid;
    bit in_reset;
  } ctrl_t;

  ctrl_t      ctrl_q[$];
  logic [7:0] data_q[$];

  int         checks = 0;
  int         failures = 0;

  logic [7:0] model [N];
  int         clr_left = 0;
  logic [7:0] clr_color_m = 8'hFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void map(input int x, input int y, output int idx, output bit ok);
    int bx, by;
    bx  = x / SC;
    by  = y / SC;
    ok  = (bx < BW) && (by < BH);
    idx = by * BW + bx;
  endfunction

  function automatic void fill(input logic [7:0] c);
    for (int i = 0; i < N; i++) model[i] = c;
  endfunction

  // One clock: drive inputs, advance the reference model, queue expectations.
  task automatic step(input bit rst, input bit cr, input logic [7:0] cc,
                      input bit we, input logic [7:0] d, input int wx, input int wy,
                      input bit re, input int rx, input int ry);
    ctrl_t e;
    bit    busy_now, wok, rok;
    int    widx, ridx;
    reset        = rst;
    clear_req    = cr;
    clear_color  = cc;
    write_enable = we;
    data_in      = d;
    data_in_x    = 11'(wx);
    data_in_y    = 11'(wy);
    read_enable  = re;
    data_out_x   = 11'(rx);
    data_out_y   = 11'(ry);
    e.busy = 0; e.drop = 0; e.valid = 0; e.in_reset = 0;
    busy_now = (clr_left > 0);
    if (rst) begin
      clr_left    = N;
      clr_color_m = 8'hFF;
      fill(8'hFF);
      e.busy      = 1;
      e.in_reset  = 1;
    end else begin
      map(wx, wy, widx, wok);
      map(rx, ry, ridx, rok);
      if (re) begin
        e.valid = 1;
        if (busy_now)  data_q.push_back(clr_color_m);
        else if (!rok) data_q.push_back(8'h00);
        else           data_q.push_back(model[ridx]);
      end
      e.drop = we && (busy_now || !wok);
      if (we && !e.drop) model[widx] = d;
      if (busy_now) clr_left--;
      else if (cr) begin
        clr_left    = N;
        clr_color_m = cc;
        fill(cc);
      end
      e.busy = (clr_left > 0);
    end
    ctrl_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int x, input int y, input logic [7:0] d);
    step(0, 0, 8'h00, 1, d, x, y, 0, 0, 0);
  endtask

  task automatic rd(input int x, input int y);
    step(0, 0, 8'h00, 0, 8'h00, 0, 0, 1, x, y);
  endtask

  task automatic read_all();
    for (int by = 0; by < BH; by++)
      for (int bx = 0; bx < BW; bx++)
        rd(bx * SC + int'($urandom_range(0, 1)), by * SC + int'($urandom_range(0, 1)));
  endtask

  // Monitor: per-cycle control checks, and a data pop whenever the DUT flags valid.
  always @(negedge clock) begin
    ctrl_t e;
    if (ctrl_q.size() > 0) begin
      e = ctrl_q.pop_front();
      chk("busy", 32'(busy), 32'(e.busy));
      chk("write_drop", 32'(write_drop), 32'(e.drop));
      chk("data_out_valid", 32'(data_out_valid), 32'(e.valid));
      if (e.in_reset) chk("data_out_in_reset", 32'(data_out), 32'h0);
    end
    if (data_out_valid === 1'b1) begin
      if (data_q.size() == 0) chk("unexpected_read", 32'(data_out_valid), 32'h0);
      else chk("data_out", 32'(data_out), 32'(data_q.pop_front()));
    end
  end

  initial begin
    // Reset, then the automatic 32-cycle fill with all ones.
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0);
    step(1, 0, 8'h00, 1, 8'h77, 2, 2, 1, 0, 0);
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0);
    idle(N);
    rd(0, 0);
    rd(15, 7);

    // Scaled addressing: (6,4) and (7,5) hit the same pixel.
    wr(6, 4, 8'h3C);
    rd(7, 5);
    idle(1);

    // Collision returns old data; later read sees new data.
    step(0, 0, 8'h00, 1, 8'h11, 6, 4, 1, 6, 4);
    rd(6, 4);

    // Out-of-range write and read.
    wr(16, 0, 8'hAB);
    rd(16, 0);
    rd(0, 8);
    rd(6, 4);
    read_all();

    // User clear, dropped write mid-clear, ignored second request.
    step(0, 1, 8'h05, 0, 8'h00, 0, 0, 0, 0, 0);
    idle(2);
    wr(2, 2, 8'hEE);
    idle(1);
    step(0, 1, 8'h09, 0, 8'h00, 0, 0, 1, 30, 30);
    idle(N);
    read_all();

    // Reset in the middle of a clear restarts it with the reset colour.
    step(0, 1, 8'h5A, 0, 8'h00, 0, 0, 0, 0, 0);
    idle(9);
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0);
    idle(N);
    read_all();

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit rst_r, cr_r, we_r, re_r;
      rst_r = ($urandom_range(0, 299) == 0);
      cr_r  = ($urandom_range(0, 59) == 0);
      we_r  = $urandom_range(0, 1) == 1;
      re_r  = $urandom_range(0, 1) == 1;
      step(rst_r, cr_r, 8'($urandom), we_r, 8'($urandom),
           int'($urandom_range(0, 19)), int'($urandom_range(0, 9)),
           re_r, int'($urandom_range(0, 19)), int'($urandom_range(0, 9)));
    end
    idle(N + 1);
    read_all();
    idle(2);

    @(negedge clock);
    #1;
    chk("ctrl_queue_drained", 32'(ctrl_q.size()), 32'h0);
    chk("data_queue_drained", 32'(data_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
